// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Staged multi-domain reset generator. Holds every domain in
//               reset for a minimum time, then releases domains one at a
//               time (bit 0 first). Restarts on PLL lock loss, a debounced
//               external request, or an optional periodic timer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous active-high reset
//   pll_locked    in   asynchronous PLL lock flag
//   ext_req       in   asynchronous external restart request, active-high
//   n_reset       out  [CHANNELS-1:0] per-domain active-low reset
//   all_released  out  high only while every domain is released (RUN)
//   busy          out  high whenever the sequencer is not in RUN
//   cause         out  [1:0] last restart cause:
//                      00 reset, 01 lock loss, 10 ext_req, 11 periodic
//   restart_count out  [7:0] saturating count of restarts
// ============================================================================
module reset_sequencer #(
    parameter int CHANNELS        = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_CYCLES    = 16,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int PERIOD_W        = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pll_locked,
    input  logic                ext_req,
    output logic [CHANNELS-1:0] n_reset,
    output logic                all_released,
    output logic                busy,
    output logic [1:0]          cause,
    output logic [7:0]          restart_count
);

    localparam int c_hold_w  = $clog2(HOLD_CYCLES + 1);
    localparam int c_stage_w = $clog2(STAGE_CYCLES + 1);
    localparam int c_deb_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_pw      = (PERIOD_W > 0) ? PERIOD_W : 1;
    localparam bit c_period_en = (PERIOD_W > 0);

    localparam logic [c_hold_w-1:0]  c_hold_max   = c_hold_w'(HOLD_CYCLES);
    localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_stage_w-1:0] c_stage_last = c_stage_w'(STAGE_CYCLES - 1);
    localparam logic [c_deb_w-1:0]   c_deb_last   = c_deb_w'(DEBOUNCE_CYCLES - 1);
    // One below all-ones: the period counter reaches all-ones on the edge
    // that leaves RUN.
    localparam logic [c_pw-1:0]      c_period_pre = ~c_pw'(1);

    localparam logic [1:0] c_cause_lock     = 2'b01;
    localparam logic [1:0] c_cause_ext      = 2'b10;
    localparam logic [1:0] c_cause_periodic = 2'b11;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'b00,
        ST_STAGE  = 2'b01,
        ST_RUN    = 2'b10
    } state_t;

    // Synchronisers and debounce
    logic               r_lock_meta;
    logic               r_lock_sync;
    logic               r_lock_prev;
    logic               r_ext_meta;
    logic               r_ext_sync;
    logic               r_ext_db;
    logic               r_ext_db_prev;
    logic [c_deb_w-1:0] r_deb_cnt;

    // FSM state, counters and registered outputs
    state_t                r_state;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [c_stage_w-1:0]  r_stage_cnt;
    logic [c_pw-1:0]       r_period_cnt;
    logic [CHANNELS-1:0]   r_n_reset;
    logic                  r_all_released;
    logic                  r_busy;
    logic [1:0]            r_cause;
    logic [7:0]            r_count;

    state_t                w_state_next;
    logic [c_hold_w-1:0]   w_hold_next;
    logic [c_stage_w-1:0]  w_stage_next;
    logic [c_pw-1:0]       w_period_next;
    logic [CHANNELS-1:0]   w_nrst_next;
    logic [1:0]            w_cause_next;
    logic [7:0]            w_count_next;
    logic [CHANNELS-1:0]   w_nrst_shift;
    logic                  w_lock_loss;
    logic                  w_ext_rise;
    logic                  w_period_hit;
    logic                  w_restart;

    // ------------------------------------------------------------------
    // Input synchronisers and ext_req debounce
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_meta   <= 1'b0;
            r_lock_sync   <= 1'b0;
            r_lock_prev   <= 1'b0;
            r_ext_meta    <= 1'b0;
            r_ext_sync    <= 1'b0;
            r_ext_db      <= 1'b0;
            r_ext_db_prev <= 1'b0;
            r_deb_cnt     <= '0;
        end else begin
            r_lock_meta   <= pll_locked;
            r_lock_sync   <= r_lock_meta;
            r_lock_prev   <= r_lock_sync;
            r_ext_meta    <= ext_req;
            r_ext_sync    <= r_ext_meta;
            r_ext_db_prev <= r_ext_db;
            // The debounced value follows only after the synchronised input
            // has disagreed with it for DEBOUNCE_CYCLES edges in a row.
            if (r_ext_sync != r_ext_db) begin
                if (r_deb_cnt == c_deb_last) begin
                    r_ext_db  <= r_ext_sync;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Release pattern: shift a 1 in from bit 0 on every stage step
    // ------------------------------------------------------------------
    generate
        if (CHANNELS > 1) begin : g_multi_chan
            assign w_nrst_shift = {r_n_reset[CHANNELS-2:0], 1'b1};
        end else begin : g_single_chan
            assign w_nrst_shift = 1'b1;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Restart triggers
    // ------------------------------------------------------------------
    // Outside ASSERT a low lock level is always a fresh loss. Inside ASSERT
    // only a falling edge counts, so a lock that is still low after reset
    // (or stays low) merely blocks the release instead of retriggering.
    assign w_lock_loss  = ~r_lock_sync & ((r_state != ST_ASSERT) | r_lock_prev);
    assign w_ext_rise   = r_ext_db & ~r_ext_db_prev;
    assign w_period_hit = c_period_en && (r_state == ST_RUN) &&
                          (r_period_cnt == c_period_pre);
    assign w_restart    = w_lock_loss | w_ext_rise | w_period_hit;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_hold_next   = r_hold_cnt;
        w_stage_next  = r_stage_cnt;
        w_period_next = r_period_cnt;
        w_nrst_next   = r_n_reset;
        w_cause_next  = r_cause;
        w_count_next  = r_count;

        if (w_restart) begin
            w_state_next  = ST_ASSERT;
            w_hold_next   = '0;
            w_stage_next  = '0;
            w_period_next = '0;
            w_nrst_next   = '0;
            if (w_lock_loss) begin
                w_cause_next = c_cause_lock;
            end else if (w_ext_rise) begin
                w_cause_next = c_cause_ext;
            end else begin
                w_cause_next = c_cause_periodic;
            end
            // A retrigger while already in ASSERT is not a new restart.
            if ((r_state != ST_ASSERT) && (r_count != 8'hFF)) begin
                w_count_next = r_count + 8'd1;
            end
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    w_nrst_next = '0;
                    if (r_hold_cnt != c_hold_max) begin
                        w_hold_next = r_hold_cnt + c_hold_w'(1);
                    end
                    // Leave on the edge the hold count reaches its target,
                    // or on any later edge once lock and ext allow it.
                    if ((r_hold_cnt >= c_hold_last) && r_lock_sync && !r_ext_db) begin
                        w_state_next = ST_STAGE;
                        w_stage_next = '0;
                    end
                end
                ST_STAGE: begin
                    if (r_stage_cnt == c_stage_last) begin
                        w_stage_next = '0;
                        w_nrst_next  = w_nrst_shift;
                        if (&w_nrst_shift) begin
                            w_state_next  = ST_RUN;
                            w_period_next = '0;
                        end
                    end else begin
                        w_stage_next = r_stage_cnt + c_stage_w'(1);
                    end
                end
                ST_RUN: begin
                    if (c_period_en) begin
                        w_period_next = r_period_cnt + c_pw'(1);
                    end
                end
                default: begin
                    w_state_next = ST_ASSERT;
                    w_nrst_next  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_ASSERT;
            r_hold_cnt     <= '0;
            r_stage_cnt    <= '0;
            r_period_cnt   <= '0;
            r_n_reset      <= '0;
            r_all_released <= 1'b0;
            r_busy         <= 1'b1;
            r_cause        <= 2'b00;
            r_count        <= 8'd0;
        end else begin
            r_state        <= w_state_next;
            r_hold_cnt     <= w_hold_next;
            r_stage_cnt    <= w_stage_next;
            r_period_cnt   <= w_period_next;
            r_n_reset      <= w_nrst_next;
            r_all_released <= (w_state_next == ST_RUN);
            r_busy         <= (w_state_next != ST_RUN);
            r_cause        <= w_cause_next;
            r_count        <= w_count_next;
        end
    end

    assign n_reset       = r_n_reset;
    assign all_released  = r_all_released;
    assign busy          = r_busy;
    assign cause         = r_cause;
    assign restart_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer. Expected output
//               snapshots are queued with the edge at which they are due and
//               compared when the simulation reaches that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       pll_locked = 1'b1;
    logic       ext_req    = 1'b0;

    logic [2:0] n_reset;
    logic       all_released;
    logic       busy;
    logic [1:0] cause;
    logic [7:0] restart_count;

    logic [2:0] n_reset_np;
    logic       all_released_np;
    logic       busy_np;
    logic [1:0] cause_np;
    logic [7:0] restart_count_np;

    always #5 clk = ~clk;

    reset_sequencer #(
        .CHANNELS(3), .HOLD_CYCLES(16), .STAGE_CYCLES(16),
        .DEBOUNCE_CYCLES(8), .PERIOD_W(8)
    ) dut (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .ext_req(ext_req),
        .n_reset(n_reset), .all_released(all_released), .busy(busy),
        .cause(cause), .restart_count(restart_count)
    );

    reset_sequencer #(
        .CHANNELS(3), .HOLD_CYCLES(16), .STAGE_CYCLES(16),
        .DEBOUNCE_CYCLES(8), .PERIOD_W(0)
    ) dut_np (
        .clk(clk), .reset(reset), .pll_locked(pll_locked), .ext_req(ext_req),
        .n_reset(n_reset_np), .all_released(all_released_np), .busy(busy_np),
        .cause(cause_np), .restart_count(restart_count_np)
    );

    // Rising edges since time zero; read only on falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    int          sb_at[$];
    logic [14:0] sb_exp[$];
    string       sb_tag[$];

    logic [14:0] obs;
    assign obs = {n_reset, all_released, busy, cause, restart_count};

    function automatic logic [14:0] snap(logic [2:0] nr, logic rel, logic bsy,
                                         logic [1:0] cs, logic [7:0] cnt);
        return {nr, rel, bsy, cs, cnt};
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_snap(string tag, logic [14:0] o, logic [14:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed n_reset=%b rel=%b busy=%b cause=%b count=%0d, expected n_reset=%b rel=%b busy=%b cause=%b count=%0d",
                   tag, o[14:12], o[11], o[10], o[9:8], o[7:0],
                   e[14:12], e[11], e[10], e[9:8], e[7:0]);
        end
    endtask

    task automatic check_val(string tag, int o, int e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, o, e);
        end
    endtask

    // Queue an expected snapshot due 'rel' rising edges from now.
    task automatic sb_push(int rel, logic [14:0] e, string tag);
        sb_at.push_back(cyc + rel);
        sb_exp.push_back(e);
        sb_tag.push_back(tag);
    endtask

    // Advance until every queued expectation has come due and been compared.
    task automatic sb_drain();
        while (sb_at.size() > 0) begin
            if (sb_at[0] <= cyc) begin
                check_snap(sb_tag[0], obs, sb_exp[0]);
                void'(sb_at.pop_front());
                void'(sb_exp.pop_front());
                void'(sb_tag.pop_front());
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_released(string tag, int limit);
        int k = 0;
        while (all_released !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, int'(all_released === 1'b1), 1);
    endtask

    task automatic wait_nreset(string tag, logic [2:0] want, int limit);
        int k = 0;
        while (n_reset !== want && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, int'(n_reset === want), 1);
    endtask

    initial begin
        int drops;

        // ---------------- power-on reset and first release -------------
        step(3);
        sb_push(0, snap(3'b000, 1'b0, 1'b1, 2'b00, 8'd0), "reset_state");
        sb_drain();
        reset = 1'b0;
        // Next rising edge is edge 1.
        sb_push(15, snap(3'b000, 1'b0, 1'b1, 2'b00, 8'd0), "hold_e15");
        sb_push(31, snap(3'b000, 1'b0, 1'b1, 2'b00, 8'd0), "stage_e31");
        sb_push(32, snap(3'b001, 1'b0, 1'b1, 2'b00, 8'd0), "ch0_e32");
        sb_push(47, snap(3'b001, 1'b0, 1'b1, 2'b00, 8'd0), "ch0_e47");
        sb_push(48, snap(3'b011, 1'b0, 1'b1, 2'b00, 8'd0), "ch1_e48");
        sb_push(63, snap(3'b011, 1'b0, 1'b1, 2'b00, 8'd0), "ch1_e63");
        sb_push(64, snap(3'b111, 1'b1, 1'b0, 2'b00, 8'd0), "run_e64");
        sb_drain();
        check_val("np_run_e64", int'(all_released_np), 1);

        // ---------------- periodic restart after 255 RUN cycles ---------
        sb_push(254, snap(3'b111, 1'b1, 1'b0, 2'b00, 8'd0), "period_254");
        sb_push(255, snap(3'b000, 1'b0, 1'b1, 2'b11, 8'd1), "period_255");
        sb_drain();

        // ---------------- PERIOD_W=0 instance never restarts -----------
        drops = 0;
        repeat (10000) begin
            @(negedge clk);
            if (all_released_np !== 1'b1) drops++;
        end
        check_val("np_no_drop", drops, 0);
        check_val("np_count", int'(restart_count_np), 0);

        // ---------------- clean restart for the trigger tests ----------
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        sb_push(64, snap(3'b111, 1'b1, 1'b0, 2'b00, 8'd0), "rerun_e64");
        sb_drain();

        // ---------------- lock loss in RUN -----------------------------
        step(10);
        pll_locked = 1'b0;
        sb_push(3, snap(3'b000, 1'b0, 1'b1, 2'b01, 8'd1), "lockloss_3e");
        sb_drain();
        // ext retrigger while in ASSERT: cause updates, count does not
        step(2);
        ext_req = 1'b1;
        sb_push(16, snap(3'b000, 1'b0, 1'b1, 2'b10, 8'd1), "ext_in_assert");
        step(12);
        ext_req = 1'b0;
        sb_drain();
        step(10);
        pll_locked = 1'b1;
        wait_nreset("relock_start", 3'b001, 200);
        sb_push(16, snap(3'b011, 1'b0, 1'b1, 2'b10, 8'd1), "relock_ch1");
        sb_push(32, snap(3'b111, 1'b1, 1'b0, 2'b10, 8'd1), "relock_run");
        sb_drain();

        // ---------------- ext_req pulses in RUN ------------------------
        step(5);
        ext_req = 1'b1;
        step(5);
        ext_req = 1'b0;
        step(20);
        sb_push(0, snap(3'b111, 1'b1, 1'b0, 2'b10, 8'd1), "short_pulse");
        sb_drain();
        ext_req = 1'b1;
        sb_push(16, snap(3'b000, 1'b0, 1'b1, 2'b10, 8'd2), "long_pulse");
        step(12);
        ext_req = 1'b0;
        sb_drain();

        // ---------------- lock loss and ext rise on the same edge ------
        // ext reaches the FSM 2 sync + 8 debounce + 1 edge after it is
        // driven; lock loss takes 3 edges, so drop lock 8 edges later.
        wait_released("run_before_coinc", 300);
        step(5);
        ext_req = 1'b1;
        step(8);
        pll_locked = 1'b0;
        sb_push(3, snap(3'b000, 1'b0, 1'b1, 2'b01, 8'd3), "coincident");
        sb_drain();
        step(1);
        ext_req = 1'b0;
        sb_push(6, snap(3'b000, 1'b0, 1'b1, 2'b01, 8'd3), "coincident_hold");
        sb_drain();
        step(5);
        pll_locked = 1'b1;

        // ---------------- 300 ext restarts saturate the counter --------
        for (int i = 0; i < 300; i++) begin
            wait_released("loop_run", 200);
            ext_req = 1'b1;
            step(12);
            ext_req = 1'b0;
        end
        sb_push(0, snap(3'b000, 1'b0, 1'b1, 2'b10, 8'd255), "saturate");
        sb_drain();

        // ---------------- asynchronous reset mid-STAGE -----------------
        wait_nreset("reach_011", 3'b011, 200);
        sb_push(0, snap(3'b011, 1'b0, 1'b1, 2'b10, 8'd255), "pre_reset");
        sb_drain();
        #2;
        reset = 1'b1;
        #1;
        sb_push(0, snap(3'b000, 1'b0, 1'b1, 2'b00, 8'd0), "async_reset");
        sb_drain();
        @(negedge clk);
        reset = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of reset domains, range 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: minimum cycles all domains stay in reset.
REQ-003 SHALL have parameter STAGE_CYCLES, default 16: gap between successive domain releases.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 8: stability window for ext_req.
REQ-005 SHALL have parameter PERIOD_W, default 26: periodic-reset counter width; 0 disables periodic reset.
REQ-006 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high.
REQ-008 SHALL have port pll_locked  input  1  asynchronous PLL lock flag.
REQ-009 SHALL have port ext_req  input  1  asynchronous button or request, active-high.
REQ-010 SHALL have port n_reset  output  CHANNELS  per-domain active-low reset; bit 0 is released first.
REQ-011 SHALL have port all_released  output  1  high only in RUN.
REQ-012 SHALL have port busy  output  1  high when state is not RUN.
REQ-013 SHALL have port cause  output  2  last restart cause: 00 reset, 01 lock loss, 10 ext_req, 11 periodic.
REQ-014 SHALL have port restart_count  output  8  number of restarts, saturating.

Function
REQ-015 SHALL synchronise pll_locked and ext_req each through a 2-FF synchroniser.
REQ-016 SHALL update debounced ext only after the synchronised ext_req holds a new value for DEBOUNCE_CYCLES consecutive cycles; shorter pulses are ignored.
REQ-017 SHALL implement FSM states ASSERT, STAGE and RUN; all outputs SHALL be registered.
REQ-018 In ASSERT: n_reset is all 0; the hold counter counts to HOLD_CYCLES and then saturates.
REQ-019 ASSERT->STAGE SHALL occur on the edge where the hold count reaches HOLD_CYCLES, provided synchronised lock=1 and debounced ext=0; otherwise ASSERT is held.
REQ-020 In STAGE: n_reset[k] SHALL rise STAGE_CYCLES*(k+1) cycles after STAGE entry.
REQ-021 Released bits SHALL remain 1 until the next ASSERT.
REQ-022 STAGE->RUN SHALL occur on the same edge n_reset[CHANNELS-1] rises; all_released=1 and busy=0 from that edge.
REQ-023 In RUN with PERIOD_W>0: the period counter counts from 0 and, on reaching 2^PERIOD_W-1, the FSM enters ASSERT with cause=11.
REQ-024 From any state, synchronised lock=0 SHALL force ASSERT with cause=01.
REQ-025 From any state, a debounced ext rising SHALL force ASSERT with cause=10.
REQ-026 Simultaneous restart triggers SHALL be resolved with priority lock loss > ext > periodic.
REQ-027 Every entry to ASSERT SHALL clear the hold, stage and period counters and drive n_reset to 0 on the same edge.
REQ-028 A retrigger while in ASSERT SHALL restart the hold counter and update cause, but SHALL NOT increment restart_count.
REQ-029 restart_count SHALL increment on each STAGE->ASSERT or RUN->ASSERT transition and saturate at 255.
REQ-030 Latency from a pll_locked fall to n_reset=0 SHALL be at most 3 clk edges.

Reset
REQ-031 While reset=1 the block SHALL immediately (asynchronously) force: state=ASSERT, n_reset=0, all_released=0, busy=1, cause=00, restart_count=0, all counters 0, synchroniser and debounce registers 0.
REQ-032 Reset asserted mid-STAGE or mid-RUN SHALL drop every n_reset bit without waiting for a clk edge.
REQ-033 Edge numbering SHALL count from the first clk edge after reset deasserts.

Verification (CHANNELS=3, HOLD=16, STAGE=16, DEBOUNCE=8, PERIOD_W=8 unless stated)
REQ-034 Bench: reset released with pll_locked=1 held -> STAGE at edge 16; n_reset=001 at edge 32, 011 at 48, 111 at 64; all_released=1 at 64; cause=00.
REQ-035 Bench: pll_locked driven 0 in RUN -> n_reset=000 within 3 edges, cause=01, restart_count=1; relock -> full release sequence repeats.
REQ-036 Bench: ext_req pulse of 5 cycles in RUN -> no change; pulse of 12 cycles -> ASSERT, cause=10, restart_count increments by 1.
REQ-037 Bench: stay in RUN -> restart after 255 RUN cycles with cause=11; with PERIOD_W=0, no restart within 10000 cycles.
REQ-038 Bench: reset pulsed while n_reset=011 -> n_reset=000 asynchronously and restart_count=0.
REQ-039 Bench: lock loss and ext rise on the same edge -> cause=01; 300 ext restarts -> restart_count=255.
